// File: rtl/keypad_digit_capture.sv
// Keypad digit capture: synchronizes the scanner's col/row, debounces
// press and release, and shifts each accepted key into a 2-digit history.
module keypad_digit_capture #(
  parameter int DEBOUNCE_CYCLES = 240000,
  parameter int CNT_W           = 18
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] col_q,
  input  logic [3:0] row_q,
  output logic [3:0] digit_new,
  output logic [3:0] digit_old,
  output logic       key_valid,
  output logic       key_held
);

  typedef enum logic [1:0] {
    IDLE,
    DEBOUNCE,
    HELD,
    RELEASE
  } state_t;

  localparam logic [CNT_W-1:0] LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [3:0]       cand;
  logic [7:0]       sync1;
  logic [7:0]       sync2;
  logic [3:0]       cs;
  logic [3:0]       rs;
  logic [1:0]       c_idx;
  logic [1:0]       r_idx;
  logic [3:0]       code;
  logic             present;
  logic             match;

  assign cs = sync2[7:4];
  assign rs = sync2[3:0];

  // Index is only meaningful when the vector is one-hot.
  function automatic logic [1:0] onehot_idx(
    input logic [3:0] v
  );
    logic [1:0] i;
    i = 2'd0;
    case (1'b1)
      v[1]:    i = 2'd1;
      v[2]:    i = 2'd2;
      v[3]:    i = 2'd3;
      default: i = 2'd0;
    endcase
    return i;
  endfunction

  assign c_idx   = onehot_idx(cs);
  assign r_idx   = onehot_idx(rs);
  assign present = $onehot(cs) && $onehot(rs);
  assign match   = present && (code == cand);

  always_comb begin
    code = 4'h0;
    case ({r_idx, c_idx})
      4'h0:    code = 4'h1;
      4'h1:    code = 4'h2;
      4'h2:    code = 4'h3;
      4'h3:    code = 4'hA;
      4'h4:    code = 4'h4;
      4'h5:    code = 4'h5;
      4'h6:    code = 4'h6;
      4'h7:    code = 4'hB;
      4'h8:    code = 4'h7;
      4'h9:    code = 4'h8;
      4'hA:    code = 4'h9;
      4'hB:    code = 4'hC;
      4'hC:    code = 4'hE;
      4'hD:    code = 4'h0;
      4'hE:    code = 4'hF;
      default: code = 4'hD;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      cand      <= '0;
      sync1     <= '0;
      sync2     <= '0;
      digit_new <= '0;
      digit_old <= '0;
      key_valid <= 1'b0;
      key_held  <= 1'b0;
    end else begin
      sync1     <= {col_q, row_q};
      sync2     <= sync1;
      key_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (present) begin
            cand  <= code;
            cnt   <= '0;
            state <= DEBOUNCE;
          end
        end
        DEBOUNCE: begin
          if (!match) begin
            state <= IDLE;
          end else if (cnt == LAST) begin
            state     <= HELD;
            digit_old <= digit_new;
            digit_new <= cand;
            key_valid <= 1'b1;
            key_held  <= 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        HELD: begin
          if (!match) begin
            cnt   <= '0;
            state <= RELEASE;
          end
        end
        RELEASE: begin
          // Same key back again is contact bounce, not a new press.
          if (match) begin
            state <= HELD;
          end else if (cnt == LAST) begin
            state    <= IDLE;
            key_held <= 1'b0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: begin
          state    <= IDLE;
          key_held <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_keypad_digit_capture.sv
// Bench for keypad_digit_capture: run-length press/release model
// compared every cycle, plus directed literal checks.
module tb_keypad_digit_capture;

  localparam int DC = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] col_q;
  logic [3:0] row_q;
  logic [3:0] digit_new;
  logic [3:0] digit_old;
  logic       key_valid;
  logic       key_held;

  int tests = 0;
  int errs  = 0;
  int npulse = 0;

  keypad_digit_capture #(
    .DEBOUNCE_CYCLES(DC),
    .CNT_W(4)
  ) dut (
    .clk(clk),
    .rst(rst),
    .col_q(col_q),
    .row_q(row_q),
    .digit_new(digit_new),
    .digit_old(digit_old),
    .key_valid(key_valid),
    .key_held(key_held)
  );

  always #5 clk = ~clk;

  // Keypad legend, index = row*4 + col.
  logic [3:0] km [16] = '{
    4'h1, 4'h2, 4'h3, 4'hA,
    4'h4, 4'h5, 4'h6, 4'hB,
    4'h7, 4'h8, 4'h9, 4'hC,
    4'hE, 4'h0, 4'hF, 4'hD
  };

  // Model state: pins delayed two edges, run length of identical
  // samples while waiting, run of non-matching samples while down.
  logic [7:0] m_s1, m_s2;
  logic [3:0] m_new, m_old, m_cand;
  logic       m_kv, m_busy, armed = 1'b0;
  int         m_run, m_gap;

  function automatic int bit_pos(input logic [3:0] v);
    for (int i = 0; i < 4; i++)
      if (v[i]) return i;
    return 0;
  endfunction

  always @(posedge clk) begin
    logic       p;
    logic [3:0] k;
    if (rst) begin
      armed = 1'b1;
      m_s1 = '0; m_s2 = '0;
      m_new = '0; m_old = '0; m_cand = '0;
      m_kv = 1'b0; m_busy = 1'b0;
      m_run = 0; m_gap = 0;
    end else if (armed) begin
      p = ($countones(m_s2[7:4]) == 1) && ($countones(m_s2[3:0]) == 1);
      k = km[bit_pos(m_s2[3:0]) * 4 + bit_pos(m_s2[7:4])];
      m_kv = 1'b0;
      if (!m_busy) begin
        if (m_run == 0) begin
          if (p) begin m_cand = k; m_run = 1; end
        end else if (p && k == m_cand) begin
          m_run++;
          if (m_run == DC + 1) begin
            m_old = m_new; m_new = m_cand; m_kv = 1'b1;
            m_busy = 1'b1; m_run = 0; m_gap = 0;
          end
        end else begin
          m_run = 0;
        end
      end else if (p && k == m_cand) begin
        m_gap = 0;
      end else begin
        m_gap++;
        if (m_gap == DC + 1) begin m_busy = 1'b0; m_gap = 0; end
      end
      m_s2 = m_s1;
      m_s1 = {col_q, row_q};
    end
  end

  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      errs++;
      $display("FAIL %s: got %0h, want %0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (armed) begin
      check("digit_new", digit_new, m_new);
      check("digit_old", digit_old, m_old);
      check("key_valid", key_valid, m_kv);
      check("key_held", key_held, m_busy);
      if (key_valid) npulse++;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic set_key(input logic [3:0] c, input logic [3:0] r);
    col_q = c;
    row_q = r;
  endtask

  // Edges from now until key_valid is seen (0 = never within budget).
  task automatic edges_to_pulse(output int n);
    n = 0;
    for (int i = 1; i <= 12; i++) begin
      tick();
      if (key_valid && n == 0) n = i;
    end
  endtask

  task automatic edges_to_drop(output int n);
    n = 0;
    for (int i = 1; i <= 12; i++) begin
      tick();
      if (!key_held && n == 0) n = i;
    end
  endtask

  initial begin
    int n, p0;
    rst = 1'b1;
    set_key(4'b0000, 4'b0000);
    tick();
    // Reset with a key driven: nothing captured.
    set_key(4'b0100, 4'b0010);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("rst_new", digit_new, 0);
      check("rst_old", digit_old, 0);
      check("rst_kv", key_valid, 0);
      check("rst_held", key_held, 0);
    end
    set_key(4'b0000, 4'b0000);
    tick();
    rst = 1'b0;
    ticks(4);

    // Clean press of "6".
    p0 = npulse;
    set_key(4'b0100, 4'b0010);
    edges_to_pulse(n);
    check("press_latency", n, 7);
    ticks(8);
    check("t2_new", digit_new, 4'h6);
    check("t2_old", digit_old, 4'h0);
    set_key(4'b0000, 4'b0000);
    edges_to_drop(n);
    check("release_latency", n, 7);
    check("t2_pulses", npulse - p0, 1);

    // "5" then "A".
    p0 = npulse;
    set_key(4'b0010, 4'b0010);
    ticks(10);
    set_key(4'b0000, 4'b0000);
    ticks(10);
    set_key(4'b1000, 4'b0001);
    ticks(10);
    set_key(4'b0000, 4'b0000);
    ticks(10);
    check("t3_new", digit_new, 4'hA);
    check("t3_old", digit_old, 4'h5);
    check("t3_pulses", npulse - p0, 2);

    // Bouncing "0", then stable, then a one-cycle dropout.
    p0 = npulse;
    for (int i = 0; i < 3; i++) begin
      set_key(4'b0010, 4'b1000);
      ticks(2);
      set_key(4'b0000, 4'b0000);
      ticks(2);
    end
    check("t4_bounce", npulse - p0, 0);
    set_key(4'b0010, 4'b1000);
    ticks(12);
    set_key(4'b0000, 4'b0000);
    tick();
    set_key(4'b0010, 4'b1000);
    ticks(12);
    check("t4_new", digit_new, 4'h0);
    check("t4_old", digit_old, 4'hA);
    check("t4_pulses", npulse - p0, 1);
    check("t4_held", key_held, 1);
    set_key(4'b0000, 4'b0000);
    ticks(12);

    // Multi-column and empty-row inputs.
    p0 = npulse;
    set_key(4'b0110, 4'b0010);
    ticks(20);
    set_key(4'b0001, 4'b0000);
    ticks(20);
    set_key(4'b0000, 4'b0000);
    ticks(4);
    check("t5_pulses", npulse - p0, 0);
    check("t5_new", digit_new, 4'h0);
    check("t5_old", digit_old, 4'hA);

    // Reset while debouncing "9"; key stays down afterwards.
    p0 = npulse;
    set_key(4'b0100, 4'b0100);
    ticks(5);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("t6_rst_old", digit_old, 0);
    check("t6_rst_held", key_held, 0);
    edges_to_pulse(n);
    check("t6_latency", n, 7);
    check("t6_new", digit_new, 4'h9);
    check("t6_old", digit_old, 4'h0);
    check("t6_pulses", npulse - p0, 1);
    set_key(4'b0000, 4'b0000);
    ticks(12);
    check("t6_held", key_held, 0);

    $display("[TB] %0d tests run, %0d failed", tests, errs);
    $finish;
  end

endmodule
